note_player: RTL and testbench
==============================

Name: note_player

Overview:
- Downstream playback stage of the piano controller.
- Accepts one note request at a time (note index, octave, duration in ms) over a start/busy/done handshake.
- Drives the buzzer with a square wave at the note frequency for the requested duration, then holds a fixed silent gap.
- The controller's free-play and auto-play logic issues requests. This block owns all buzzer timing.

Parameters:
- TICK_CYCLES, 100000, clk cycles per millisecond tick (100 MHz clock).
- GAP_MS, 20, silent inter-note gap in ms.
- DUR_BITS, 16, width of the duration field.
- SIM_SHIFT, 0, right-shift applied to every half-period for fast simulation; 0 in synthesis.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous active-high reset
- start  in  1  request strobe; sampled only in IDLE
- note  in  3  0 = rest, 1..7 = do..ti
- octave  in  2  0 low, 1 middle, 2 high, 3 treated as high
- dur_ms  in  DUR_BITS  tone length in ms
- abort  in  1  cancel current note
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at normal completion
- buzzer  out  1  square-wave output to the buzzer pin

Behaviour:
- Clocking and reset:
  - Single clock domain, synchronous active-high reset on clk.
  - Reset: state IDLE, busy=0, done=0, buzzer=0, all counters 0. Reset mid-note takes effect at the next edge; no done pulse.
- States:
  - IDLE, PLAY, GAP.
  - busy is registered: high from the cycle after acceptance until the cycle the FSM re-enters IDLE.
- IDLE:
  - On start=1, latch note/octave/dur_ms; the acceptance cycle is cycle 0.
  - dur_ms!=0: PLAY at cycle 1.
  - dur_ms==0: GAP at cycle 1.
  - start outside IDLE is ignored; inputs are not re-sampled.
- Half-period table (middle octave, cycles):
  - 1:191110, 2:170265, 3:151685, 4:143172, 5:127551, 6:113636, 7:101239.
  - Low octave = value<<1; high octave = value>>1.
  - Final value >>SIM_SHIFT.
  - 20-bit arithmetic; no overflow (max 382220).
- PLAY:
  - Millisecond prescaler counts 0..TICK_CYCLES-1; ms counter increments on each wrap.
  - PLAY lasts exactly dur_ms*TICK_CYCLES cycles, then GAP.
  - Tone counter starts at 0 on PLAY entry with buzzer=0.
  - When tone counter == half-1: buzzer toggles and the counter clears.
  - note==0 (rest): buzzer held 0 for the whole PLAY.
  - Leaving PLAY forces buzzer=0 on the same edge, regardless of phase.
- GAP:
  - buzzer=0 for exactly GAP_MS*TICK_CYCLES cycles, then IDLE with done=1 for that one cycle (busy=0 in the same cycle).
  - GAP_MS=0: GAP lasts 0 cycles; PLAY goes directly to IDLE+done.
  - start in the done cycle is accepted (IDLE), allowing back-to-back notes.
- abort:
  - Synchronous; priority below rst, above everything else.
  - In PLAY/GAP: next edge gives IDLE, buzzer=0, busy=0, no done.
  - In IDLE: ignored. If start and abort are both high in IDLE, start wins.
- Counters:
  - Prescaler, ms counter and tone counter clear on every state entry.
  - ms counter is DUR_BITS wide.
  - dur_ms = max (65535) must complete without wrap.

Test Plan:
- SIM_SHIFT=10, TICK_CYCLES=100, GAP_MS=2. rst high 2 cycles -> busy=0, done=0, buzzer=0.
- start with note=6, octave=1, dur=3 -> busy rises at cycle 1; buzzer toggles every 110 cycles (113636>>10=110); PLAY 300 cycles; buzzer=0 for 200 cycles; done pulse exactly 1 cycle at cycle 501.
- note=1 with octave 0, 2, 3 -> half-periods 373, 93, 93 cycles.
- note=0, dur=2 -> buzzer stays 0 for 200 cycles; done at cycle 401. dur=0 -> done at cycle 201.
- abort asserted at cycle 150 of a dur=3 note -> IDLE at cycle 151, buzzer=0, no done. Second start during PLAY has no effect on timing.
- start re-asserted in the done cycle -> new note accepted; busy low for only that one cycle. rst at mid-GAP -> outputs 0 next cycle, no done.

Source files
------------

// File: rtl/note_player.sv
// Note playback stage: takes one note request (note, octave, duration) and
// drives the buzzer with a square wave for that long, followed by a silent gap.
module note_player #(
    parameter int TICK_CYCLES = 100000,
    parameter int GAP_MS      = 20,
    parameter int DUR_BITS    = 16,
    parameter int SIM_SHIFT   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [2:0]          note,
    input  logic [1:0]          octave,
    input  logic [DUR_BITS-1:0] dur_ms,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                buzzer
);

    localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICK_CYCLES - 1);
    localparam logic [DUR_BITS-1:0] GAP_LAST = DUR_BITS'((GAP_MS > 0) ? GAP_MS - 1 : 0);
    localparam bit                  HAS_GAP  = (GAP_MS > 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t              state_r;
    logic                rest_r;
    logic [DUR_BITS-1:0] dur_r;
    logic [19:0]         half_r;
    logic [PRE_W-1:0]    pre_r;
    logic [DUR_BITS-1:0] ms_r;
    logic [19:0]         tone_r;
    logic                busy_r;
    logic                done_r;
    logic                buzzer_r;

    logic tick_wrap_s;
    logic play_last_s;
    logic gap_last_s;
    logic tone_wrap_s;

    // Middle-octave half periods in clk cycles at 100 MHz.
    function automatic logic [19:0] base_half(input logic [2:0] n);
        logic [19:0] h;
        case (n)
            3'd1:    h = 20'd191110;
            3'd2:    h = 20'd170265;
            3'd3:    h = 20'd151685;
            3'd4:    h = 20'd143172;
            3'd5:    h = 20'd127551;
            3'd6:    h = 20'd113636;
            3'd7:    h = 20'd101239;
            default: h = 20'd0;
        endcase
        return h;
    endfunction

    // Octave scaling plus simulation shift; never returns 0 so half-1 stays sane.
    function automatic logic [19:0] half_period(input logic [2:0] n, input logic [1:0] oct);
        logic [19:0] b;
        logic [19:0] h;
        b = base_half(n);
        case (oct)
            2'd0:    h = b << 1;
            2'd1:    h = b;
            default: h = b >> 1;
        endcase
        h = h >> SIM_SHIFT;
        if (h == 20'd0) begin
            h = 20'd1;
        end else begin
            h = h;
        end
        return h;
    endfunction

    // Terminal-count decodes for the prescaler, ms counter and tone counter.
    always_comb begin
        tick_wrap_s = (pre_r == PRE_LAST);
        play_last_s = tick_wrap_s && (ms_r == (dur_r - DUR_BITS'(1)));
        gap_last_s  = tick_wrap_s && (ms_r == GAP_LAST);
        tone_wrap_s = (tone_r == (half_r - 20'd1));
    end

    // Playback FSM with all counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            rest_r   <= 1'b1;
            dur_r    <= '0;
            half_r   <= '0;
            pre_r    <= '0;
            ms_r     <= '0;
            tone_r   <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            buzzer_r <= 1'b0;
        end else if (abort && (state_r != IDLE)) begin
            state_r  <= IDLE;
            pre_r    <= '0;
            ms_r     <= '0;
            tone_r   <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            buzzer_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    buzzer_r <= 1'b0;
                    pre_r    <= '0;
                    ms_r     <= '0;
                    tone_r   <= '0;
                    if (start) begin
                        rest_r <= (note == 3'd0);
                        dur_r  <= dur_ms;
                        half_r <= half_period(note, octave);
                        if (dur_ms != '0) begin
                            state_r <= PLAY;
                            busy_r  <= 1'b1;
                        end else if (HAS_GAP) begin
                            state_r <= GAP;
                            busy_r  <= 1'b1;
                        end else begin
                            // Zero tone and zero gap: finish immediately.
                            done_r <= 1'b1;
                        end
                    end
                end

                PLAY: begin
                    if (play_last_s) begin
                        pre_r    <= '0;
                        ms_r     <= '0;
                        tone_r   <= '0;
                        buzzer_r <= 1'b0;
                        if (HAS_GAP) begin
                            state_r <= GAP;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        if (tick_wrap_s) begin
                            pre_r <= '0;
                            ms_r  <= ms_r + DUR_BITS'(1);
                        end else begin
                            pre_r <= pre_r + PRE_W'(1);
                        end
                        if (rest_r) begin
                            buzzer_r <= 1'b0;
                        end else if (tone_wrap_s) begin
                            buzzer_r <= ~buzzer_r;
                            tone_r   <= '0;
                        end else begin
                            tone_r <= tone_r + 20'd1;
                        end
                    end
                end

                GAP: begin
                    buzzer_r <= 1'b0;
                    if (gap_last_s) begin
                        state_r <= IDLE;
                        pre_r   <= '0;
                        ms_r    <= '0;
                        tone_r  <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (tick_wrap_s) begin
                        pre_r <= '0;
                        ms_r  <= ms_r + DUR_BITS'(1);
                    end else begin
                        pre_r <= pre_r + PRE_W'(1);
                    end
                end

                default: begin
                    state_r  <= IDLE;
                    pre_r    <= '0;
                    ms_r     <= '0;
                    tone_r   <= '0;
                    busy_r   <= 1'b0;
                    buzzer_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign buzzer = buzzer_r;

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: expected buzzer edges and done pulses are
// queued per request and matched against what the DUT produces cycle by cycle.
module tb_note_player;

    localparam int TICK  = 100;
    localparam int GAPM  = 2;
    localparam int SHIFT = 10;
    localparam int DB    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    note = 3'd0;
    logic [1:0]    octave = 2'd0;
    logic [DB-1:0] dur_ms = '0;
    logic          busy;
    logic          done;
    logic          buzzer;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int cyc;
        bit is_done;
        bit val;
    } ev_t;

    ev_t exp_q[$];

    always #5 clk = ~clk;

    note_player #(
        .TICK_CYCLES(TICK),
        .GAP_MS     (GAPM),
        .DUR_BITS   (DB),
        .SIM_SHIFT  (SHIFT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .note  (note),
        .octave(octave),
        .dur_ms(dur_ms),
        .abort (abort),
        .busy  (busy),
        .done  (done),
        .buzzer(buzzer)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // cutoff = cycle during which abort/rst is held (0 = none).
    task automatic push_expect(input int dur, input int half, input bit rest, input int cutoff);
        int  p;
        int  play_end;
        int  n;
        ev_t e;
        p        = dur * TICK;
        play_end = (cutoff != 0 && cutoff < p) ? cutoff : p;
        n        = 0;
        if (!rest) begin
            for (int m = 1; m * half + 1 <= play_end; m++) begin
                e.cyc = m * half + 1; e.is_done = 1'b0; e.val = m[0];
                exp_q.push_back(e);
                n++;
            end
            if (n % 2 == 1) begin
                e.cyc = play_end + 1; e.is_done = 1'b0; e.val = 1'b0;
                exp_q.push_back(e);
            end
        end
        if (cutoff == 0) begin
            e.cyc = p + GAPM * TICK + 1; e.is_done = 1'b1; e.val = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_start(input logic [2:0] n, input logic [1:0] o, input int d);
        note   = n;
        octave = o;
        dur_ms = DB'(d);
        start  = 1'b1;
    endtask

    // poke_kind: 0 none, 1 start with pn/po/pd, 2 abort, 3 rst; held during cycle poke_cyc.
    task automatic watch(input string name, input int limit, input int poke_cyc, input int poke_kind,
                         input logic [2:0] pn, input logic [1:0] po, input int pd);
        logic prev_bz;
        bit   seen_done;
        bit   ev;
        bit   is_d;
        bit   v;
        ev_t  e;
        prev_bz   = buzzer;
        seen_done = 1'b0;
        for (int c = 1; c <= limit; c++) begin
            step();
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
            if (c == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy_rise: got %b want 1", name, busy);
                end
            end
            if (c == poke_cyc + 1 && (poke_kind == 2 || poke_kind == 3)) begin
                checks++;
                if ({busy, done, buzzer} !== 3'b000) begin
                    errors++;
                    $display("FAIL %s cancel_outputs: busy/done/buzzer=%b want 000", name, {busy, done, buzzer});
                end
            end
            ev = 1'b0; is_d = 1'b0; v = 1'b0;
            if (buzzer !== prev_bz) begin
                ev = 1'b1; v = buzzer;
            end else if (done === 1'b1) begin
                ev = 1'b1; is_d = 1'b1;
            end
            prev_bz = buzzer;
            if (ev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected_event: cyc=%0d done=%0d buzzer=%0d want none", name, c, is_d, v);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != c || e.is_done != is_d || e.val != v) begin
                        errors++;
                        $display("FAIL %s event: got cyc=%0d done=%0d buzzer=%0d want cyc=%0d done=%0d buzzer=%0d",
                                 name, c, is_d, v, e.cyc, e.is_done, e.val);
                    end
                end
            end
            if (done === 1'b1) begin
                seen_done = 1'b1;
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_in_done: got %b want 0", name, busy);
                end
            end
            if (c == poke_cyc) begin
                case (poke_kind)
                    1: drive_start(pn, po, pd);
                    2: abort = 1'b1;
                    3: rst = 1'b1;
                    default: ;
                endcase
            end
            if (seen_done) break;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_events: got %0d left want 0 (next cyc=%0d)", name, exp_q.size(), exp_q[0].cyc);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++;
        if (buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer: got %b want 0", buzzer); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_tone();
        push_expect(3, 110, 1'b0, 0);
        drive_start(3'd6, 2'd1, 3);
        watch("tone_n6", 520, 0, 0, 3'd0, 2'd0, 0);
    endtask

    task automatic test_octaves();
        push_expect(8, 373, 1'b0, 0);
        drive_start(3'd1, 2'd0, 8);
        watch("oct_low", 1020, 0, 0, 3'd0, 2'd0, 0);
        push_expect(3, 93, 1'b0, 0);
        drive_start(3'd1, 2'd2, 3);
        watch("oct_high", 520, 0, 0, 3'd0, 2'd0, 0);
        push_expect(3, 93, 1'b0, 0);
        drive_start(3'd1, 2'd3, 3);
        watch("oct_3", 520, 0, 0, 3'd0, 2'd0, 0);
    endtask

    task automatic test_rest();
        push_expect(2, 1, 1'b1, 0);
        drive_start(3'd0, 2'd1, 2);
        watch("rest", 420, 0, 0, 3'd0, 2'd0, 0);
        push_expect(0, 1, 1'b0, 0);
        drive_start(3'd5, 2'd1, 0);
        watch("dur0", 220, 0, 0, 3'd0, 2'd0, 0);
    endtask

    task automatic test_abort();
        push_expect(3, 110, 1'b0, 150);
        drive_start(3'd6, 2'd1, 3);
        watch("abort", 520, 150, 2, 3'd0, 2'd0, 0);
    endtask

    task automatic test_start_ignored();
        push_expect(3, 110, 1'b0, 0);
        drive_start(3'd6, 2'd1, 3);
        watch("start_in_play", 520, 50, 1, 3'd1, 2'd0, 1);
    endtask

    task automatic test_start_abort();
        push_expect(1, 124, 1'b0, 0);
        drive_start(3'd5, 2'd1, 1);
        abort = 1'b1;
        watch("start_abort_idle", 320, 0, 0, 3'd0, 2'd0, 0);
    endtask

    task automatic test_back_to_back();
        push_expect(1, 148, 1'b0, 0);
        drive_start(3'd3, 2'd1, 1);
        watch("b2b_first", 320, 301, 1, 3'd7, 2'd2, 2);
        push_expect(2, 49, 1'b0, 0);
        watch("b2b_second", 420, 0, 0, 3'd0, 2'd0, 0);
    endtask

    task automatic test_rst_gap();
        push_expect(1, 110, 1'b0, 200);
        drive_start(3'd6, 2'd1, 1);
        watch("rst_gap", 400, 200, 3, 3'd0, 2'd0, 0);
    endtask

    initial begin
        test_reset();
        test_tone();
        test_octaves();
        test_rest();
        test_abort();
        test_start_ignored();
        test_start_abort();
        test_back_to_back();
        test_rst_gap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
